// File: rtl/prefetch_pkg.sv
// Shared opcode, entry and default-width definitions for the prefetch data path.
// No logic; pure types.
// No flow control of its own.
package prefetch_pkg;

    localparam int PR_ADDR_BITS       = 64;
    localparam int PR_LOG_QUEUE_SIZE  = 6;
    localparam int PR_DATA_WIDTH      = 64;
    localparam int PR_BURST_LEN_WIDTH = 8;
    localparam int PR_TID_WIDTH       = 8;

    typedef enum logic [2:0] {
        NOP               = 3'd0,
        READ_REQ_PREF     = 3'd1,
        READ_REQ_MASTER   = 3'd2,
        READ_DATA_SLAVE   = 3'd3,
        READ_DATA_PROMISE = 3'd4
    } pr_op_t;

    typedef struct packed {
        logic [0:PR_ADDR_BITS-1]  addr;
        logic                     valid;
        logic                     promised;
        logic [0:PR_DATA_WIDTH-1] data;
    } pr_entry_t;

endpackage

// File: rtl/prefetch_data_queue_if.sv
// Controller <-> data-queue bundle: command, master request, DDR beat and status.
// Purely wiring; no latency.
// No handshake: the controller only issues commands the status bits allow.
interface prefetch_data_queue_if
    import prefetch_pkg::*;
#(
    parameter int ADDR_BITS       = PR_ADDR_BITS,
    parameter int LOG_QUEUE_SIZE  = PR_LOG_QUEUE_SIZE,
    parameter int DATA_WIDTH      = PR_DATA_WIDTH,
    parameter int BURST_LEN_WIDTH = PR_BURST_LEN_WIDTH,
    parameter int TID_WIDTH       = PR_TID_WIDTH
);
    logic                         pr_flush;
    logic [0:2]                   pr_opCode;
    logic [0:ADDR_BITS-1]         s_ar_addr;
    logic [0:BURST_LEN_WIDTH-1]   s_ar_len;
    logic [0:TID_WIDTH-1]         s_ar_id;
    logic [0:DATA_WIDTH-1]        m_r_data;

    logic                         pr_addrHit;
    logic                         pr_hasOutstanding;
    logic [0:LOG_QUEUE_SIZE]      pr_reqCnt;
    logic                         pr_almostFull;
    logic                         pr_context_valid;
    logic                         pr_r_valid;
    logic [0:DATA_WIDTH-1]        s_r_data;
    logic [0:ADDR_BITS-1]         pr_m_ar_addr;
    logic [0:BURST_LEN_WIDTH-1]   pr_m_ar_len;
    logic [0:TID_WIDTH-1]         pr_m_ar_id;
    logic                         pr_err;

    modport master (
        output pr_flush, pr_opCode, s_ar_addr, s_ar_len, s_ar_id, m_r_data,
        input  pr_addrHit, pr_hasOutstanding, pr_reqCnt, pr_almostFull, pr_context_valid,
               pr_r_valid, s_r_data, pr_m_ar_addr, pr_m_ar_len, pr_m_ar_id, pr_err
    );

    modport slave (
        input  pr_flush, pr_opCode, s_ar_addr, s_ar_len, s_ar_id, m_r_data,
        output pr_addrHit, pr_hasOutstanding, pr_reqCnt, pr_almostFull, pr_context_valid,
               pr_r_valid, s_r_data, pr_m_ar_addr, pr_m_ar_len, pr_m_ar_id, pr_err
    );
endinterface

// File: rtl/prefetch_ring_ptr.sv
// Ring pointer with a wrap bit in the MSB; clear beats load beats increment.
// New value visible one cycle after the request.
// No backpressure; the caller gates inc/ld.
module prefetch_ring_ptr #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         clr,
    input  logic         inc,
    input  logic         ld,
    input  logic [0:W-1] ld_val,
    output logic [0:W-1] ptr
);
    logic [0:W-1] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr)      ptr_d = '0;
        else if (ld)  ptr_d = ld_val;
        else if (inc) ptr_d = ptr_q + W'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/prefetch_data_queue.sv
// Stride prefetcher data queue: executes pr_opCode on a circular request/data ring.
// Status outputs reflect a command one cycle after it is sampled; pr_addrHit is combinational.
// No backpressure: illegal commands are dropped (sticky pr_err when PREFETCH_DATA_ERR_EN).
module prefetch_data_queue
    import prefetch_pkg::*;
#(
    parameter int ADDR_BITS       = PR_ADDR_BITS,
    parameter int LOG_QUEUE_SIZE  = PR_LOG_QUEUE_SIZE,
    parameter int DATA_WIDTH      = PR_DATA_WIDTH,
    parameter int BURST_LEN_WIDTH = PR_BURST_LEN_WIDTH,
    parameter int TID_WIDTH       = PR_TID_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetN,
    prefetch_data_queue_if.slave  bus
);
    localparam int QDEPTH = 1 << LOG_QUEUE_SIZE;
    localparam int PW     = LOG_QUEUE_SIZE + 1;
    localparam logic [0:PW-1] AFULL_TH = PW'(QDEPTH - 1);

    logic [0:PW-1] head_p, fill_p, prom_p, tail_p, occ;
    logic [0:LOG_QUEUE_SIZE-1] head_idx, fill_idx, prom_idx, tail_idx;
    logic head_inc, fill_inc, prom_inc, prom_ld, tail_inc;
    logic full, illegal;

    logic [0:DATA_WIDTH-1] data_mem [QDEPTH];
    logic [0:ADDR_BITS-1]  addr_mem [QDEPTH];
    logic                  data_we, addr_we;
    logic [0:ADDR_BITS-1]  addr_wdat;

    logic [0:QDEPTH-1]          valid_q, valid_d, promised_q, promised_d;
    logic [0:ADDR_BITS-1]       stride_q, stride_d, last_q, last_d, prev_q, prev_d;
    logic                       prev_vld_q, prev_vld_d, ctx_vld_q, ctx_vld_d;
    logic [0:BURST_LEN_WIDTH-1] len_q, len_d;
    logic [0:TID_WIDTH-1]       id_q, id_d;
    pr_op_t                     op;

    prefetch_ring_ptr #(.W(PW)) u_head (.clk(clk), .resetN(resetN), .clr(bus.pr_flush),
        .inc(head_inc), .ld(1'b0), .ld_val('0), .ptr(head_p));
    prefetch_ring_ptr #(.W(PW)) u_fill (.clk(clk), .resetN(resetN), .clr(bus.pr_flush),
        .inc(fill_inc), .ld(1'b0), .ld_val('0), .ptr(fill_p));
    prefetch_ring_ptr #(.W(PW)) u_prom (.clk(clk), .resetN(resetN), .clr(bus.pr_flush),
        .inc(prom_inc), .ld(prom_ld), .ld_val(tail_p + PW'(1)), .ptr(prom_p));
    prefetch_ring_ptr #(.W(PW)) u_tail (.clk(clk), .resetN(resetN), .clr(bus.pr_flush),
        .inc(tail_inc), .ld(1'b0), .ld_val('0), .ptr(tail_p));

    assign head_idx = head_p[1:LOG_QUEUE_SIZE];
    assign fill_idx = fill_p[1:LOG_QUEUE_SIZE];
    assign prom_idx = prom_p[1:LOG_QUEUE_SIZE];
    assign tail_idx = tail_p[1:LOG_QUEUE_SIZE];
    assign occ      = tail_p - head_p;
    assign full     = (tail_idx == head_idx) && (tail_p[0] != head_p[0]);
    assign op       = pr_op_t'(bus.pr_opCode);

    assign bus.pr_addrHit        = (prom_p != tail_p) && (addr_mem[prom_idx] == bus.s_ar_addr);
    assign bus.pr_hasOutstanding = (fill_p != tail_p);
    assign bus.pr_reqCnt         = tail_p - prom_p;
    assign bus.pr_almostFull     = (occ >= AFULL_TH);
    assign bus.pr_context_valid  = ctx_vld_q;
    assign bus.pr_r_valid        = valid_q[head_idx] & promised_q[head_idx] & (head_p != tail_p);
    assign bus.s_r_data          = data_mem[head_idx];
    assign bus.pr_m_ar_addr      = last_q + stride_q;
    assign bus.pr_m_ar_len       = len_q;
    assign bus.pr_m_ar_id        = id_q;

    always_comb begin
        head_inc = 1'b0; fill_inc = 1'b0; prom_inc = 1'b0; prom_ld = 1'b0; tail_inc = 1'b0;
        data_we = 1'b0; addr_we = 1'b0; addr_wdat = bus.pr_m_ar_addr; illegal = 1'b0;
        valid_d = valid_q; promised_d = promised_q; stride_d = stride_q; last_d = last_q;
        prev_d = prev_q; prev_vld_d = prev_vld_q; ctx_vld_d = ctx_vld_q; len_d = len_q; id_d = id_q;
        if (bus.pr_flush) begin
            valid_d = '0; promised_d = '0; stride_d = '0; ctx_vld_d = 1'b0; prev_vld_d = 1'b0;
        end else begin
            case (op)
                NOP: ;
                READ_REQ_PREF: begin
                    if (full) illegal = 1'b1;
                    else begin
                        addr_we = 1'b1; tail_inc = 1'b1;
                        valid_d[tail_idx] = 1'b0; promised_d[tail_idx] = 1'b0;
                        last_d = bus.pr_m_ar_addr;
                    end
                end
                READ_REQ_MASTER: begin
                    if (bus.pr_addrHit) begin
                        promised_d[prom_idx] = 1'b1; prom_inc = 1'b1;
                    end else if (full) illegal = 1'b1;
                    else begin
                        // A miss skips any unpromised entries: prom jumps past the new one.
                        addr_we = 1'b1; addr_wdat = bus.s_ar_addr; tail_inc = 1'b1; prom_ld = 1'b1;
                        valid_d[tail_idx] = 1'b0; promised_d[tail_idx] = 1'b1;
                        if (!ctx_vld_q) begin
                            ctx_vld_d = 1'b1; len_d = bus.s_ar_len; id_d = bus.s_ar_id;
                        end
                        if (prev_vld_q) stride_d = bus.s_ar_addr - prev_q;
                        prev_d = bus.s_ar_addr; prev_vld_d = 1'b1; last_d = bus.s_ar_addr;
                    end
                end
                READ_DATA_SLAVE: begin
                    if (fill_p == tail_p) illegal = 1'b1;
                    else begin
                        data_we = 1'b1; valid_d[fill_idx] = 1'b1; fill_inc = 1'b1;
                    end
                end
                READ_DATA_PROMISE: begin
                    if (!bus.pr_r_valid) illegal = 1'b1;
                    else begin
                        valid_d[head_idx] = 1'b0; promised_d[head_idx] = 1'b0; head_inc = 1'b1;
                    end
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    // Payload and address storage hold no reset; flush leaves data in place.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[fill_idx] <= bus.m_r_data;
        if (addr_we) addr_mem[tail_idx] <= addr_wdat;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid_q <= '0; promised_q <= '0; stride_q <= '0; last_q <= '0; prev_q <= '0;
            prev_vld_q <= 1'b0; ctx_vld_q <= 1'b0; len_q <= '0; id_q <= '0;
        end else begin
            valid_q <= valid_d; promised_q <= promised_d; stride_q <= stride_d; last_q <= last_d;
            prev_q <= prev_d; prev_vld_q <= prev_vld_d; ctx_vld_q <= ctx_vld_d;
            len_q <= len_d; id_q <= id_d;
        end
    end

`ifdef PREFETCH_DATA_ERR_EN
    logic err_q, err_d;
    assign err_d = err_q | illegal;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) err_q <= 1'b0;
        else         err_q <= err_d;
    end
    assign bus.pr_err = err_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal;
    assign bus.pr_err = 1'b0;
`endif
endmodule

// File: tb/tb_prefetch_data_queue.sv
// Directed bench for prefetch_data_queue: stride learning, hit/promise, fill/pop, full, flush, reset.
module tb_prefetch_data_queue;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic exp_err;

    always #5 clk = ~clk;

    prefetch_data_queue_if bus ();
    prefetch_data_queue dut (.clk(clk), .resetN(resetN), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [2:0] code);
        bus.pr_opCode = code;
        @(posedge clk);
        #1;
        bus.pr_opCode = 3'd0;
    endtask

    initial begin
`ifdef PREFETCH_DATA_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        bus.pr_flush = 1'b0; bus.pr_opCode = 3'd0; bus.m_r_data = '0;
        bus.s_ar_addr = '0; bus.s_ar_len = '0; bus.s_ar_id = '0;
        #3;
        @(negedge clk);
        resetN = 1'b1;
        #1;
        chk("rst_reqCnt", 64'(bus.pr_reqCnt), 64'd0);
        chk("rst_hasOut", 64'(bus.pr_hasOutstanding), 64'd0);
        chk("rst_rvalid", 64'(bus.pr_r_valid), 64'd0);
        chk("rst_afull", 64'(bus.pr_almostFull), 64'd0);
        chk("rst_ctx", 64'(bus.pr_context_valid), 64'd0);
        chk("rst_addrHit", 64'(bus.pr_addrHit), 64'd0);
        chk("rst_m_ar_addr", 64'(bus.pr_m_ar_addr), 64'd0);
        chk("rst_m_ar_len", 64'(bus.pr_m_ar_len), 64'd0);
        chk("rst_m_ar_id", 64'(bus.pr_m_ar_id), 64'd0);
        chk("rst_err", 64'(bus.pr_err), 64'd0);

        // Two master misses teach context and a +0x40 stride.
        bus.s_ar_addr = 64'hdeadbeef; bus.s_ar_len = 8'd4; bus.s_ar_id = 8'd3;
        op(3'd2);
        chk("ctx_after_first", 64'(bus.pr_context_valid), 64'd1);
        bus.s_ar_addr = 64'hdeadbf2f; bus.s_ar_len = 8'd9; bus.s_ar_id = 8'd7;
        op(3'd2);
        chk("m_ar_addr_stride", 64'(bus.pr_m_ar_addr), 64'hdeadbf6f);
        chk("m_ar_len_held", 64'(bus.pr_m_ar_len), 64'd4);
        chk("m_ar_id_held", 64'(bus.pr_m_ar_id), 64'd3);
        chk("reqCnt_two_miss", 64'(bus.pr_reqCnt), 64'd0);
        chk("hasOut_two_miss", 64'(bus.pr_hasOutstanding), 64'd1);
        chk("hit_prom_eq_tail", 64'(bus.pr_addrHit), 64'd0);

        for (int i = 0; i < 3; i++) op(3'd1);
        chk("reqCnt_3pref", 64'(bus.pr_reqCnt), 64'd3);
        chk("m_ar_addr_3pref", 64'(bus.pr_m_ar_addr), 64'hdeadc02f);
        bus.s_ar_addr = 64'hdeadbfaf; #1;
        chk("hit_wrong_addr", 64'(bus.pr_addrHit), 64'd0);
        bus.s_ar_addr = 64'hdeadbf6f; #1;
        chk("hit_right_addr", 64'(bus.pr_addrHit), 64'd1);
        op(3'd2);
        chk("reqCnt_after_hit", 64'(bus.pr_reqCnt), 64'd2);
        chk("rvalid_no_data", 64'(bus.pr_r_valid), 64'd0);

        bus.m_r_data = 64'hA0;
        op(3'd3);
        chk("rvalid_after_fill", 64'(bus.pr_r_valid), 64'd1);
        chk("s_r_data_first", 64'(bus.s_r_data), 64'hA0);
        for (int i = 1; i < 5; i++) begin
            bus.m_r_data = 64'(8'hA0 + i);
            op(3'd3);
        end
        chk("hasOut_all_filled", 64'(bus.pr_hasOutstanding), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("pop_rvalid", 64'(bus.pr_r_valid), 64'd1);
            chk("pop_data", 64'(bus.s_r_data), 64'(8'hA0 + i));
            op(3'd4);
        end
        chk("rvalid_unpromised", 64'(bus.pr_r_valid), 64'd0);
        chk("s_r_data_head3", 64'(bus.s_r_data), 64'hA3);

        // Fill to occupancy 62, 63, then 64 across the pointer wrap.
        for (int i = 0; i < 60; i++) op(3'd1);
        chk("afull_at_62", 64'(bus.pr_almostFull), 64'd0);
        op(3'd1);
        chk("afull_at_63", 64'(bus.pr_almostFull), 64'd1);
        chk("err_before_full", 64'(bus.pr_err), 64'd0);
        op(3'd1);
        chk("reqCnt_full", 64'(bus.pr_reqCnt), 64'd64);
        chk("m_ar_addr_full", 64'(bus.pr_m_ar_addr), 64'hdeadcfaf);
        op(3'd1);
        chk("reqCnt_pref_rejected", 64'(bus.pr_reqCnt), 64'd64);
        chk("m_ar_addr_rejected", 64'(bus.pr_m_ar_addr), 64'hdeadcfaf);
        chk("err_pref_full", 64'(bus.pr_err), 64'(exp_err));
        bus.s_ar_addr = 64'h1234; op(3'd2);
        chk("reqCnt_miss_full", 64'(bus.pr_reqCnt), 64'd64);
        op(3'd5);
        op(3'd4);
        chk("reqCnt_illegal_ops", 64'(bus.pr_reqCnt), 64'd64);
        chk("afull_still", 64'(bus.pr_almostFull), 64'd1);
        chk("hasOut_before_flush", 64'(bus.pr_hasOutstanding), 64'd1);

        bus.pr_flush = 1'b1;
        op(3'd3);
        bus.pr_flush = 1'b0;
        chk("flush_hasOut", 64'(bus.pr_hasOutstanding), 64'd0);
        chk("flush_reqCnt", 64'(bus.pr_reqCnt), 64'd0);
        chk("flush_ctx", 64'(bus.pr_context_valid), 64'd0);
        chk("flush_afull", 64'(bus.pr_almostFull), 64'd0);
        chk("flush_rvalid", 64'(bus.pr_r_valid), 64'd0);
        chk("flush_keeps_err", 64'(bus.pr_err), 64'(exp_err));

        bus.s_ar_addr = 64'h1000; bus.s_ar_len = 8'd9; bus.s_ar_id = 8'd7;
        op(3'd2);
        chk("relearn_len", 64'(bus.pr_m_ar_len), 64'd9);
        chk("relearn_id", 64'(bus.pr_m_ar_id), 64'd7);
        chk("relearn_m_ar_addr", 64'(bus.pr_m_ar_addr), 64'h1000);
        chk("relearn_hasOut", 64'(bus.pr_hasOutstanding), 64'd1);

        // Asynchronous reset between clock edges.
        resetN = 1'b0;
        #1;
        chk("async_rst_hasOut", 64'(bus.pr_hasOutstanding), 64'd0);
        chk("async_rst_ctx", 64'(bus.pr_context_valid), 64'd0);
        chk("async_rst_err", 64'(bus.pr_err), 64'd0);
        chk("async_rst_len", 64'(bus.pr_m_ar_len), 64'd0);
        @(negedge clk);
        resetN = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prefetch_data_queue.md
# prefetch_data_queue

Data path of the stride prefetcher, directly downstream of the prefetch controller. It executes the controller's `pr_opCode` commands on a circular request queue and learns the burst context and stride from master read requests. It generates the next prefetch address and stores returned DDR data until the NVDLA consumes it. All status bits the controller polls come from this block.

## Interface
Parameters:
- ADDR_BITS, 64, address width
- LOG_QUEUE_SIZE, 6, queue depth = 2^LOG_QUEUE_SIZE entries
- DATA_WIDTH, 64, stored payload per entry
- BURST_LEN_WIDTH, 8, AXI len width
- TID_WIDTH, 8, AXI ID width

Ports (all vectors big-endian `[0:W-1]`):
- clk  in  1  sole clock; every flop samples on its rising edge
- resetN  in  1  asynchronous, active-low reset
- pr_flush  in  1  synchronous queue/context clear
- pr_opCode  in  3  command, sampled each rising edge
- s_ar_addr / s_ar_len / s_ar_id  in  ADDR_BITS / BURST_LEN_WIDTH / TID_WIDTH  master request fields
- m_r_data  in  DATA_WIDTH  DDR beat, written on READ_DATA_SLAVE
- pr_addrHit  out  1  s_ar_addr equals oldest unpromised entry address (combinational)
- pr_hasOutstanding  out  1  entries issued but data not yet returned
- pr_reqCnt  out  LOG_QUEUE_SIZE+1  unpromised entry count
- pr_almostFull  out  1  occupancy ≥ 2^LOG_QUEUE_SIZE − 1
- pr_context_valid  out  1  len/id learned
- pr_r_valid  out  1  head entry valid and promised
- s_r_data  out  DATA_WIDTH  head payload
- pr_m_ar_addr / pr_m_ar_len / pr_m_ar_id  out  per widths  next prefetch request
- pr_err  out  1  sticky illegal-command flag (see Configuration)

## Operation
- Entry fields: addr, valid (data returned), promised (owned by a master request), data.
- Four pointers, each LOG_QUEUE_SIZE+1 bits with a wrap bit:
  - head: oldest entry.
  - fill: oldest entry awaiting data.
  - prom: oldest unpromised entry.
  - tail: next free slot.
- Ordering invariant: head ≤ prom ≤ tail and head ≤ fill ≤ tail. DDR returns data in order.
- Derived outputs:
  - occupancy = tail − head
  - pr_reqCnt = tail − prom
  - pr_hasOutstanding = (fill ≠ tail)
  - pr_r_valid = head valid & promised & (head ≠ tail)
  - s_r_data = data[head]
- Opcodes:
  - 0 NOP: no change.
  - 1 READ_REQ_PREF: enqueue {pr_m_ar_addr, unpromised}; lastAddr ← pr_m_ar_addr.
  - 2 READ_REQ_MASTER with pr_addrHit=1: set promised at prom; prom++.
  - 2 READ_REQ_MASTER with pr_addrHit=0: enqueue {s_ar_addr, promised}; prom ← tail+1. Also:
    - If context is invalid: capture len/id and set pr_context_valid.
    - If a previous master address exists: stride ← s_ar_addr − prevMaster.
    - prevMaster ← s_ar_addr; lastAddr ← s_ar_addr.
  - 3 READ_DATA_SLAVE: data[fill] ← m_r_data; valid[fill] ← 1; fill++.
  - 4 READ_DATA_PROMISE: pop head; clear valid/promised.
- pr_m_ar_addr = lastAddr + stride, modulo 2^ADDR_BITS; the stride is two's complement. pr_m_ar_len and pr_m_ar_id are the captured context.
- Illegal commands leave state unchanged and set pr_err:
  - opcode 1 or 2-miss when the queue is full
  - opcode 3 when fill = tail
  - opcode 4 when pr_r_valid = 0
  - opcodes 5–7
- pr_flush has priority over any opcode in the same cycle. It zeroes all pointers, valid/promised bits, stride, context_valid and prevMaster-valid. It does not clear data or pr_err.

## Timing
- Reset: all pointers = 0, context_valid = 0, stride = 0, pr_err = 0. Consequently:
  - pr_hasOutstanding = 0, pr_r_valid = 0, pr_reqCnt = 0, pr_almostFull = 0
  - pr_m_ar_addr = 0, pr_m_ar_len = 0, pr_m_ar_id = 0
  - s_r_data is undefined.
- Latency: an opcode sampled at edge N updates status outputs after edge N.
- pr_addrHit is combinational from s_ar_addr and the prom entry. It is 0 when prom = tail.
- Opcode 3 and 4 in consecutive cycles on the same entry: pr_r_valid rises the cycle after opcode 3.
- A full queue with simultaneous pr_flush: flush wins and the queue is empty next cycle.
- Pointer wrap: the 2^LOG_QUEUE_SIZE boundary is handled by the wrap bit. Full = indices equal, wrap bits differ.
- resetN asserted mid-operation clears state immediately, asynchronously.

## Configuration
- PREFETCH_DATA_ERR_EN defined: pr_err is a sticky register, cleared only by reset.
- Undefined: pr_err is tied 0. Illegal commands are still ignored.

## Structure
- Shared package `prefetch_pkg`:
  - opcode enum pr_op_t: NOP=0, READ_REQ_PREF=1, READ_REQ_MASTER=2, READ_DATA_SLAVE=3, READ_DATA_PROMISE=4
  - entry struct typedef
- One sub-module, `prefetch_ring_ptr`: a wrap-bit pointer with increment/clear, instantiated four times.

## Test plan
- Reset → all outputs zero, pr_context_valid=0.
- Opcode 2 at 0xdeadbeef (len 4, id 3), then opcode 2 at 0xdeadbf2f → stride=0x40, pr_m_ar_addr=0xdeadbf6f, pr_m_ar_len=4, pr_m_ar_id=3, pr_reqCnt=0, pr_hasOutstanding=1.
- Opcode 1 three times, then s_ar_addr=0xdeadbf6f → pr_reqCnt=3, pr_addrHit=1. Opcode 2 → pr_reqCnt=2.
- Opcode 3 ×5 with data 0xA0..0xA4, then opcode 4 ×3 → s_r_data sequence 0xA0, 0xA1, 0xA2. pr_r_valid=0 afterwards, since the remaining entries are unpromised.
- Fill 64 entries → pr_almostFull=1 at 63. A 65th opcode 1 → tail unchanged, pr_err=1 (with the macro defined).
- pr_flush together with opcode 3 while outstanding → next cycle: pr_hasOutstanding=0, pr_reqCnt=0, pr_context_valid=0.
